// File: rtl/rx_frame_buffer.sv
// Receive frame buffer: synchronizes the shift-register frame into the system clock,
// checks start/stop/parity, and queues byte+flags in a show-ahead FIFO for the host.
module rx_frame_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              RecievedFlag,
  input  logic [10:0]       DataParl,
  input  logic [1:0]        ParityType,
  input  logic              DataReady,
  output logic [7:0]        DataOut,
  output logic              DataValid,
  output logic              ParityError,
  output logic              StartError,
  output logic              StopError,
  output logic              Overrun,
  output logic [ADDR_W:0]   Fill
);

  logic              sync1, sync2, sync3;
  logic              strobe;
  logic              parityBit, parityErr;
  logic [10:0]       capEntry, headEntry;
  logic [10:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic [ADDR_W:0]   fill;
  logic              overrunReg;
  logic              full, push, pop;

  // Synchronizer resets high so a flag already asserted at reset release is ignored.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= RecievedFlag;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign strobe = sync2 & ~sync3;

  always_comb begin
    parityBit = ^DataParl[9:1];
    parityErr = 1'b0;
    case (ParityType)
      2'b01:   parityErr = ~parityBit;
      2'b10:   parityErr = parityBit;
      default: parityErr = 1'b0;
    endcase
    capEntry = {~DataParl[10], DataParl[0], parityErr, DataParl[8:1]};
  end

  assign full      = (fill == (ADDR_W+1)'(DEPTH));
  assign DataValid = (fill != '0);
  assign pop       = DataValid & DataReady;
  assign push      = strobe & (~full | pop);

  // Storage is cleared on reset so the show-ahead outputs are never X.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      mem <= '{default: '0};
    end else if (push) begin
      mem[wrPtr] <= capEntry;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fill       <= '0;
      overrunReg <= 1'b0;
    end else begin
      overrunReg <= strobe & full & ~pop;
      if (push) wrPtr <= wrPtr + ADDR_W'(1);
      if (pop)  rdPtr <= rdPtr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (ADDR_W+1)'(1);
        2'b01:   fill <= fill - (ADDR_W+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  assign headEntry   = mem[rdPtr];
  assign DataOut     = headEntry[7:0];
  assign ParityError = headEntry[8];
  assign StartError  = headEntry[9];
  assign StopError   = headEntry[10];
  assign Overrun     = overrunReg;
  assign Fill        = fill;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Scoreboard bench for rx_frame_buffer: frames are issued with a known capture edge,
// and a queue-based model predicts the head entry, fill and overrun every cycle.
module tb_rx_frame_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              Clock = 1'b0;
  logic              ResetN;
  logic              RecievedFlag;
  logic [10:0]       DataParl;
  logic [1:0]        ParityType;
  logic              DataReady;
  logic [7:0]        DataOut;
  logic              DataValid;
  logic              ParityError;
  logic              StartError;
  logic              StopError;
  logic              Overrun;
  logic [ADDR_W:0]   Fill;

  rx_frame_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .ResetN(ResetN), .RecievedFlag(RecievedFlag), .DataParl(DataParl),
    .ParityType(ParityType), .DataReady(DataReady), .DataOut(DataOut),
    .DataValid(DataValid), .ParityError(ParityError), .StartError(StartError),
    .StopError(StopError), .Overrun(Overrun), .Fill(Fill)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
    logic       sterr;
    int         capEdge;
  } entry_t;

  entry_t inflight[$];
  entry_t model[$];
  int     checks = 0;
  int     failures = 0;
  int     edgeCount = 0;
  int     readyMode = 0;
  int     pulseEdge = -1;
  int     overrunSeen = 0;
  bit     inReset = 1'b1;
  bit     expOverrun = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: data byte, inverted stop, raw start, parity by counting ones.
  function automatic entry_t expectEntry(input logic [10:0] f, input logic [1:0] pt, input int cap);
    entry_t e;
    int ones;
    ones = $countones(f[9:1]);
    e.data  = f[8:1];
    e.serr  = (f[0] != 1'b0);
    e.sterr = (f[10] != 1'b1);
    if (pt == 2'b01)      e.perr = (ones % 2 == 0);
    else if (pt == 2'b10) e.perr = (ones % 2 == 1);
    else                  e.perr = 1'b0;
    e.capEdge = cap;
    return e;
  endfunction

  always @(posedge Clock) edgeCount <= edgeCount + 1;

  // Ready driver
  initial begin
    DataReady = 1'b0;
    forever begin
      @(posedge Clock);
      #2;
      case (readyMode)
        0: DataReady = 1'b0;
        1: DataReady = 1'b1;
        2: DataReady = 1'($urandom_range(0, 1));
        default: DataReady = (pulseEdge == edgeCount + 1);
      endcase
    end
  end

  // Monitor: compare outputs to the model, then advance the model across the next edge.
  always @(negedge Clock) begin
    if (inReset) begin
      model.delete();
      inflight.delete();
      expOverrun = 1'b0;
    end else begin
      bit     doPop;
      entry_t it;
      check("DataValid", int'(DataValid), int'(model.size() != 0));
      check("Fill", int'(Fill), model.size());
      check("Overrun", int'(Overrun), int'(expOverrun));
      if (Overrun) overrunSeen++;
      if (model.size() != 0) begin
        check("DataOut", int'(DataOut), int'(model[0].data));
        check("ParityError", int'(ParityError), int'(model[0].perr));
        check("StartError", int'(StartError), int'(model[0].serr));
        check("StopError", int'(StopError), int'(model[0].sterr));
      end
      doPop = (model.size() != 0) && (DataReady === 1'b1);
      if (doPop) void'(model.pop_front());
      expOverrun = 1'b0;
      if (inflight.size() != 0 && inflight[0].capEdge == edgeCount + 1) begin
        it = inflight.pop_front();
        if (model.size() < DEPTH) model.push_back(it);
        else expOverrun = 1'b1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic sendFrame(input logic [10:0] f, input logic [1:0] pt, input int hold, input int gap);
    DataParl     = f;
    ParityType   = pt;
    RecievedFlag = 1'b1;
    inflight.push_back(expectEntry(f, pt, edgeCount + 3));
    repeat (hold) @(posedge Clock);
    #1;
    RecievedFlag = 1'b0;
    DataParl     = 11'($urandom);
    repeat (gap) @(posedge Clock);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ovBefore;
    ResetN       = 1'b0;
    RecievedFlag = 1'b1;
    DataParl     = 11'b1_0_01010101_0;
    ParityType   = 2'b10;
    inReset      = 1'b1;
    waitCycles(3);
    check("reset_Fill", int'(Fill), 0);
    check("reset_DataValid", int'(DataValid), 0);
    ResetN  = 1'b1;
    inReset = 1'b0;
    // Flag held high through release must not be captured.
    waitCycles(8);
    RecievedFlag = 1'b0;
    waitCycles(3);

    // Error-flag frames with no host activity.
    readyMode = 0;
    sendFrame(11'b1_0_01010101_0, 2'b10, 3, 2);
    sendFrame(11'b1_0_01010101_0, 2'b01, 3, 2);
    sendFrame(11'b1_0_01010101_1, 2'b00, 3, 2);
    sendFrame(11'b0_0_01010101_0, 2'b11, 3, 2);
    readyMode = 1;
    waitCycles(DEPTH + 3);

    // Overflow: five frames into a four-deep FIFO.
    readyMode = 0;
    ovBefore = overrunSeen;
    for (int i = 1; i <= 5; i++) sendFrame({1'b1, 1'b0, 8'(i), 1'b0}, 2'b00, 3, 2);
    waitCycles(2);
    check("overrun_pulses", overrunSeen - ovBefore, 1);
    readyMode = 1;
    waitCycles(DEPTH + 3);

    // Full FIFO, pop coincides with the capture strobe.
    readyMode = 0;
    for (int i = 0; i < DEPTH; i++) sendFrame({1'b1, 1'b0, 8'(8'h10 + i), 1'b0}, 2'b00, 3, 2);
    ovBefore  = overrunSeen;
    pulseEdge = edgeCount + 3;
    readyMode = 3;
    sendFrame({1'b1, 1'b0, 8'hE7, 1'b0}, 2'b00, 3, 2);
    check("coincide_no_overrun", overrunSeen - ovBefore, 0);
    readyMode = 1;
    waitCycles(DEPTH + 3);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      readyMode = $urandom_range(0, 2);
      sendFrame(11'($urandom), 2'($urandom), $urandom_range(3, 5), $urandom_range(2, 4));
    end
    readyMode = 1;
    waitCycles(DEPTH + 4);

    // Reset while three entries are queued.
    readyMode = 0;
    for (int i = 0; i < 3; i++) sendFrame({1'b1, 1'b0, 8'(8'hA0 + i), 1'b0}, 2'b10, 3, 2);
    waitCycles(2);
    check("pre_reset_Fill", int'(Fill), 3);
    inReset = 1'b1;
    ResetN  = 1'b0;
    #1;
    check("rst_DataValid", int'(DataValid), 0);
    check("rst_Fill", int'(Fill), 0);
    check("rst_DataOut", int'(DataOut), 0);
    check("rst_ParityError", int'(ParityError), 0);
    check("rst_StartError", int'(StartError), 0);
    check("rst_StopError", int'(StopError), 0);
    check("rst_Overrun", int'(Overrun), 0);
    waitCycles(2);
    ResetN  = 1'b1;
    inReset = 1'b0;
    waitCycles(3);
    sendFrame(11'b1_1_00111100_0, 2'b10, 3, 2);
    sendFrame(11'b1_0_11110001_0, 2'b01, 3, 2);
    readyMode = 1;
    waitCycles(DEPTH + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
